// File: rtl/delayed_update_unit_if.sv
// Load-side handshake bundle for delayed_update_unit: a producer (master)
// presents a channel, value, delay and mode; the unit (slave) answers with
// a combinational ready.
interface delayed_update_unit_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int DELAY_W  = 4,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic               load_valid;
  logic               load_ready;
  logic [CH_W-1:0]    load_chan;
  logic [WIDTH-1:0]   load_data;
  logic [DELAY_W-1:0] load_delay;
  logic               load_periodic;

  modport master (
    output load_valid,
    output load_chan,
    output load_data,
    output load_delay,
    output load_periodic,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_chan,
    input  load_data,
    input  load_delay,
    input  load_periodic,
    output load_ready
  );
endinterface

// File: rtl/delayed_update_unit.sv
// Multi-channel delayed register updater. Each channel stages a value,
// counts a programmable delay down and then commits the value to its output
// slice with a one-cycle strobe; periodic channels re-commit every delay+1
// cycles until stopped. A stop always wins over a commit in the same cycle.
module delayed_update_unit #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int DELAY_W  = 4,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  delayed_update_unit_if.slave        load_bus,
  input  logic [CHANNELS-1:0]         stop,
  output logic [CHANNELS*WIDTH-1:0]   out_data,
  output logic [CHANNELS-1:0]         out_update,
  output logic [CHANNELS-1:0]         busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  logic ready_s;

  // Ready for the addressed channel only; an out-of-range channel matches no
  // index and therefore stays not-ready.
  always_comb begin
    ready_s = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (load_bus.load_chan == CH_W'(k)) begin
        ready_s = !busy[k] && !stop[k];
      end else begin
        ready_s = ready_s;
      end
    end
  end

  assign load_bus.load_ready = ready_s;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    state_t             state_r;
    state_t             state_nxt_s;
    logic [WIDTH-1:0]   stage_r;
    logic [WIDTH-1:0]   out_r;
    logic [DELAY_W-1:0] reload_r;
    logic [DELAY_W-1:0] cnt_r;
    logic               periodic_r;
    logic               upd_r;
    logic               accept_s;
    logic               busy_s;
    logic               commit_s;

    assign accept_s = load_bus.load_valid && ready_s &&
                      (load_bus.load_chan == CH_W'(k));

    // Channel state register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_r <= ST_IDLE;
      end else begin
        state_r <= state_nxt_s;
      end
    end

    // Next state: an accepted load arms the channel; stop or a one-shot
    // commit disarms it.
    always_comb begin
      state_nxt_s = state_r;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_nxt_s = ST_WAIT;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (stop[k]) begin
            state_nxt_s = ST_IDLE;
          end else if (commit_s && !periodic_r) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end

    // State decode: busy while waiting; commit when the count is exhausted
    // and no stop is pending.
    always_comb begin
      busy_s   = 1'b0;
      commit_s = 1'b0;
      case (state_r)
        ST_WAIT: begin
          busy_s   = 1'b1;
          commit_s = !stop[k] && (cnt_r == '0);
        end
        ST_IDLE: begin
          busy_s   = 1'b0;
          commit_s = 1'b0;
        end
        default: begin
          busy_s   = 1'b0;
          commit_s = 1'b0;
        end
      endcase
    end

    // Datapath: latch a load, count down, commit and optionally reload.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_r    <= '0;
        reload_r   <= '0;
        cnt_r      <= '0;
        periodic_r <= 1'b0;
        out_r      <= '0;
        upd_r      <= 1'b0;
      end else begin
        upd_r <= commit_s;
        if (accept_s) begin
          stage_r    <= load_bus.load_data;
          reload_r   <= load_bus.load_delay;
          cnt_r      <= load_bus.load_delay;
          periodic_r <= load_bus.load_periodic;
        end else if (busy_s && !stop[k]) begin
          if (cnt_r != '0) begin
            cnt_r <= cnt_r - DELAY_W'(1);
          end else if (periodic_r) begin
            cnt_r <= reload_r;
          end
        end
        if (commit_s) begin
          out_r <= stage_r;
        end
      end
    end

    assign out_data[k*WIDTH +: WIDTH] = out_r;
    assign out_update[k]              = upd_r;
    assign busy[k]                    = busy_s;
  end

endmodule

// File: tb/tb_delayed_update_unit.sv
// Bench for delayed_update_unit: a directed vector table, hand-written
// corner sequences, and randomized traffic against a time-based model.
module tb_delayed_update_unit;
  localparam int WIDTH    = 4;
  localparam int CHANNELS = 2;
  localparam int DELAY_W  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] stop;
  logic [7:0] out_data;
  logic [1:0] out_update;
  logic [1:0] busy;

  always #5 clk = ~clk;

  delayed_update_unit_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DELAY_W(DELAY_W)) bus ();

  delayed_update_unit #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DELAY_W(DELAY_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_bus   (bus.slave),
    .stop       (stop),
    .out_data   (out_data),
    .out_update (out_update),
    .busy       (busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each armed channel remembers the absolute cycle of its
  // next commit and its period.
  int         cyc = 0;
  bit         m_act    [CHANNELS];
  int         m_next   [CHANNELS];
  int         m_period [CHANNELS];
  bit         m_per    [CHANNELS];
  logic [3:0] m_stage  [CHANNELS];
  logic [3:0] m_out    [CHANNELS];
  bit         m_upd    [CHANNELS];
  logic       obs_ready;

  task automatic m_reset();
    for (int k = 0; k < CHANNELS; k++) begin
      m_act[k] = 0; m_next[k] = 0; m_period[k] = 0; m_per[k] = 0;
      m_stage[k] = 4'h0; m_out[k] = 4'h0; m_upd[k] = 0;
    end
  endtask

  // One clock cycle: drive inputs, check ready, clock, advance model, check outputs.
  task automatic cycle(input bit v, input int ch, input logic [3:0] d,
                       input logic [3:0] dl, input bit p, input logic [1:0] st);
    bit rdy;
    logic [7:0] e_out;
    logic [1:0] e_upd, e_busy;
    bus.load_valid    = v;
    bus.load_chan     = ch[0];
    bus.load_data     = d;
    bus.load_delay    = dl;
    bus.load_periodic = p;
    stop              = st;
    #1;
    rdy = !m_act[ch] && !st[ch];
    obs_ready = bus.load_ready;
    chk("load_ready", {31'd0, bus.load_ready}, {31'd0, rdy});
    @(posedge clk);
    cyc++;
    for (int k = 0; k < CHANNELS; k++) begin
      m_upd[k] = 0;
      if (m_act[k]) begin
        if (st[k]) begin
          m_act[k] = 0;
        end else if (cyc == m_next[k]) begin
          m_out[k] = m_stage[k];
          m_upd[k] = 1;
          if (m_per[k]) m_next[k] += m_period[k];
          else          m_act[k] = 0;
        end
      end else if (v && rdy && ch == k) begin
        m_act[k]    = 1;
        m_stage[k]  = d;
        m_per[k]    = p;
        m_period[k] = int'(dl) + 1;
        m_next[k]   = cyc + int'(dl) + 1;
      end
    end
    #1;
    e_out  = {m_out[1], m_out[0]};
    e_upd  = {m_upd[1], m_upd[0]};
    e_busy = {m_act[1], m_act[0]};
    chk("out_data",   {24'd0, out_data},   {24'd0, e_out});
    chk("out_update", {30'd0, out_update}, {30'd0, e_upd});
    chk("busy",       {30'd0, busy},       {30'd0, e_busy});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 4'h0, 4'h0, 1'b0, 2'b00);
  endtask

  typedef struct {
    bit         v;
    int         ch;
    logic [3:0] d;
    logic [3:0] dl;
    bit         p;
    logic [1:0] st;
    bit         e_rdy;
    logic [1:0] e_upd;
    logic [1:0] e_busy;
    logic [7:0] e_out;
  } vec_t;

  function automatic vec_t mk(input bit v, input int ch, input logic [3:0] d,
                              input logic [3:0] dl, input bit p, input logic [1:0] st,
                              input bit e_rdy, input logic [1:0] e_upd,
                              input logic [1:0] e_busy, input logic [7:0] e_out);
    vec_t r;
    r.v = v; r.ch = ch; r.d = d; r.dl = dl; r.p = p; r.st = st;
    r.e_rdy = e_rdy; r.e_upd = e_upd; r.e_busy = e_busy; r.e_out = e_out;
    return r;
  endfunction

  vec_t tbl [18];

  initial begin
    // One-shot ch0, data 1, delay 5: commit six edges after the load edge.
    tbl[0] = mk(1'b1, 0, 4'h1, 4'h5, 1'b0, 2'b00, 1'b1, 2'b00, 2'b01, 8'h00);
    for (int i = 1; i <= 5; i++)
      tbl[i] = mk(1'b0, 0, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b01, 8'h00);
    tbl[6] = mk(1'b0, 0, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 8'h01);
    tbl[7] = mk(1'b0, 0, 4'h0, 4'h0, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 8'h01);
    // Periodic ch1, data A, delay 2: pulses every 3 cycles, stopped at T+7.
    tbl[8]  = mk(1'b1, 1, 4'hA, 4'h2, 1'b1, 2'b00, 1'b1, 2'b00, 2'b10, 8'h01);
    tbl[9]  = mk(1'b0, 1, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b10, 8'h01);
    tbl[10] = mk(1'b0, 1, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b10, 8'h01);
    tbl[11] = mk(1'b0, 1, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 2'b10, 2'b10, 8'hA1);
    tbl[12] = mk(1'b0, 1, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b10, 8'hA1);
    tbl[13] = mk(1'b0, 1, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b10, 8'hA1);
    tbl[14] = mk(1'b0, 1, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 2'b10, 2'b10, 8'hA1);
    tbl[15] = mk(1'b0, 1, 4'h0, 4'h0, 1'b0, 2'b10, 1'b0, 2'b00, 2'b00, 8'hA1);
    tbl[16] = mk(1'b0, 1, 4'h0, 4'h0, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 8'hA1);
    tbl[17] = mk(1'b0, 1, 4'h0, 4'h0, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 8'hA1);

    rst_n = 1'b0;
    bus.load_valid = 1'b0; bus.load_chan = 1'b0; bus.load_data = 4'h0;
    bus.load_delay = 4'h0; bus.load_periodic = 1'b0; stop = 2'b00;
    m_reset();
    @(negedge clk); @(negedge clk);
    chk("reset_out_data",   {24'd0, out_data},   32'd0);
    chk("reset_out_update", {30'd0, out_update}, 32'd0);
    chk("reset_busy",       {30'd0, busy},       32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].v, tbl[i].ch, tbl[i].d, tbl[i].dl, tbl[i].p, tbl[i].st);
      chk($sformatf("tbl%0d_ready", i),  {31'd0, obs_ready},  {31'd0, tbl[i].e_rdy});
      chk($sformatf("tbl%0d_update", i), {30'd0, out_update}, {30'd0, tbl[i].e_upd});
      chk($sformatf("tbl%0d_busy", i),   {30'd0, busy},       {30'd0, tbl[i].e_busy});
      chk($sformatf("tbl%0d_data", i),   {24'd0, out_data},   {24'd0, tbl[i].e_out});
    end

    // Delay 0 one-shot, then a back-to-back delay 0 load after the commit.
    cycle(1'b1, 0, 4'h7, 4'h0, 1'b0, 2'b00);
    idle(1);
    chk("d0_first_update", {30'd0, out_update}, 32'd1);
    chk("d0_first_data",   {28'd0, out_data[3:0]}, 32'd7);
    chk("d0_first_busy",   {31'd0, busy[0]}, 32'd0);
    cycle(1'b1, 0, 4'h3, 4'h0, 1'b0, 2'b00);
    chk("d0_second_ready", {31'd0, obs_ready}, 32'd1);
    idle(1);
    chk("d0_second_update", {30'd0, out_update}, 32'd1);
    chk("d0_second_data",   {28'd0, out_data[3:0]}, 32'd3);

    // Two channels committing on the same edge.
    cycle(1'b1, 0, 4'h5, 4'h3, 1'b0, 2'b00);
    cycle(1'b1, 1, 4'h9, 4'h2, 1'b0, 2'b00);
    idle(2);
    chk("same_edge_early", {30'd0, out_update}, 32'd0);
    idle(1);
    chk("same_edge_update", {30'd0, out_update}, 32'd3);
    chk("same_edge_data",   {24'd0, out_data}, 32'h95);

    // Load together with stop on an idle channel is refused.
    cycle(1'b1, 0, 4'hF, 4'h0, 1'b0, 2'b01);
    chk("stop_load_ready", {31'd0, obs_ready}, 32'd0);
    chk("stop_load_busy",  {30'd0, busy}, 32'd0);
    idle(1);
    chk("stop_load_noupd", {30'd0, out_update}, 32'd0);
    chk("stop_load_data",  {28'd0, out_data[3:0]}, 32'd5);

    // Load on a busy channel is refused; original commit time and value hold.
    cycle(1'b1, 0, 4'hC, 4'h4, 1'b0, 2'b00);
    cycle(1'b1, 0, 4'h2, 4'h0, 1'b0, 2'b00);
    chk("busy_load_ready", {31'd0, obs_ready}, 32'd0);
    idle(3);
    chk("busy_load_early", {30'd0, out_update}, 32'd0);
    idle(1);
    chk("busy_load_update", {30'd0, out_update}, 32'd1);
    chk("busy_load_data",   {28'd0, out_data[3:0]}, 32'hC);

    // Reset in the middle of a countdown.
    cycle(1'b1, 0, 4'h6, 4'hA, 1'b0, 2'b00);
    idle(4);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_data", {24'd0, out_data}, 32'd0);
    chk("midrst_busy",     {30'd0, busy}, 32'd0);
    chk("midrst_update",   {30'd0, out_update}, 32'd0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    chk("midrst_ready_after", {31'd0, obs_ready}, 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [1:0] st;
      st[0] = ($urandom_range(0, 7) == 0);
      st[1] = ($urandom_range(0, 7) == 0);
      cycle($urandom_range(0, 1) == 1, int'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 4)),
            $urandom_range(0, 3) == 0, st);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
